// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   rx             serial input (idle high, asynchronous to clk)
//   rd_en          pop strobe for the FIFO head
//   clr_err        clears the sticky overrun / frame_error flags
//   data_o         FIFO head byte, valid while empty=0
//   empty, full    FIFO occupancy flags, derived from the registered count
//   count          number of bytes stored
//   overrun        sticky: a received byte was dropped because the FIFO was full
//   frame_error    sticky: a stop bit was sampled low
module uart_rx_fifo #(
  parameter int unsigned CLOCK_FREQ  = 25000000,
  parameter int unsigned BIT_RATE    = 115200,
  parameter int unsigned BUFFER_SIZE = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    data_o,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(BUFFER_SIZE):0]  count,
  output logic                          overrun,
  output logic                          frame_error
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BIT_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned PTR_W        = $clog2(BUFFER_SIZE);
  localparam int unsigned CNT_W        = PTR_W + 1;

  localparam logic [BAUD_W-1:0] HALF_LIMIT = BAUD_W'(HALF_BIT - 1);
  localparam logic [BAUD_W-1:0] FULL_LIMIT = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DEPTH      = CNT_W'(BUFFER_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t            state, state_d;
  logic [BAUD_W-1:0] baud_cnt, baud_d;
  logic [2:0]        bit_idx, idx_d;
  logic [7:0]        shift, shift_d;
  logic              rx_meta, rxs;
  logic              push_c, ferr_c;

  logic [7:0]        mem [BUFFER_SIZE];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              do_push, do_pop, ovr_set;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_idx  <= idx_d;
      shift    <= shift_d;
    end
  end

  // Next-state logic; the baud counter restarts from zero on every transition
  // and after every data sample.
  always_comb begin
    state_d = state;
    baud_d  = baud_cnt + BAUD_W'(1);
    idx_d   = bit_idx;
    shift_d = shift;
    push_c  = 1'b0;
    ferr_c  = 1'b0;
    case (state)
      S_IDLE: begin
        baud_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (baud_cnt == HALF_LIMIT) begin
          baud_d = '0;
          if (!rxs) begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (baud_cnt == FULL_LIMIT) begin
          baud_d          = '0;
          shift_d[bit_idx] = rxs;
          if (bit_idx == 3'd7) state_d = S_STOP;
          else                 idx_d   = bit_idx + 3'd1;
        end
      end
      S_STOP: begin
        if (baud_cnt == FULL_LIMIT) begin
          baud_d = '0;
          if (rxs) begin
            push_c  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_c  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Hold off until the line returns high so a break yields one error, not a stream of 0x00.
        baud_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // A push into a full FIFO only succeeds when a pop frees the slot in the same cycle.
  assign do_pop  = rd_en && (count != '0);
  assign do_push = push_c && ((count != DEPTH) || do_pop);
  assign ovr_set = push_c && !do_push;

  // Storage needs no reset: data_o is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shift;
  end

  // Pointers, occupancy and sticky flags; a new error wins over clr_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overrun     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (ovr_set)      overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (ferr_c)       frame_error <= 1'b1;
      else if (clr_err) frame_error <= 1'b0;
    end
  end

  assign empty  = (count == '0);
  assign full   = (count == DEPTH);
  assign data_o = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: table-driven frame/pop/clear vectors followed by
// hand-written sequences for glitch, pop-while-full, framing error and reset.
module tb_uart_rx_fifo;

  localparam int unsigned CPB = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] data_o;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       overrun;
  logic       frame_error;

  int n_vec = 0;
  int n_err = 0;

  uart_rx_fifo #(
    .CLOCK_FREQ (1000000),
    .BIT_RATE   (100000),
    .BUFFER_SIZE(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .data_o     (data_o),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overrun    (overrun),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {OP_FRAME, OP_POP, OP_CLR} op_t;

  typedef struct {
    op_t        op;
    logic [7:0] din;
    logic       chk_head;
    logic [7:0] exp_head;
    logic [2:0] exp_count;
    logic       exp_ovr;
    logic       exp_fe;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_status(input string tag, input logic [2:0] c, input logic ovr, input logic fe);
    check({tag, " count"},       32'(count),       32'(c));
    check({tag, " empty"},       32'(empty),       32'(c == 3'd0));
    check({tag, " full"},        32'(full),        32'(c == 3'd4));
    check({tag, " overrun"},     32'(overrun),     32'(ovr));
    check({tag, " frame_error"}, 32'(frame_error), 32'(fe));
  endtask

  // Start bit begins just after a rising edge; each bit lasts CPB clocks.
  // With pop_at_stop, rd_en is high on the 8th stop-bit edge, the edge on which
  // the receiver takes its stop sample.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int stop_clks,
                            input bit pop_at_stop);
    @(posedge clk);
    #1;
    for (int b = 0; b < 10; b++) begin
      int n;
      n  = (b == 9) ? stop_clks : int'(CPB);
      rx = (b == 0) ? 1'b0 : (b == 9) ? stop_bit : d[b-1];
      for (int c = 0; c < n; c++) begin
        rd_en = pop_at_stop && (b == 9) && (c == 7);
        @(posedge clk);
        #1;
      end
    end
    rx    = 1'b1;
    rd_en = 1'b0;
  endtask

  task automatic pop(input string tag, input bit chk_head, input logic [7:0] exp_head);
    @(posedge clk);
    #1;
    if (chk_head) check({tag, " head"}, 32'(data_o), 32'(exp_head));
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{OP_FRAME, 8'hA5, 1'b1, 8'hA5, 3'd1, 1'b0, 1'b0};
    vecs[1]  = '{OP_POP,   8'h00, 1'b1, 8'hA5, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{OP_FRAME, 8'h01, 1'b1, 8'h01, 3'd1, 1'b0, 1'b0};
    vecs[3]  = '{OP_FRAME, 8'h02, 1'b1, 8'h01, 3'd2, 1'b0, 1'b0};
    vecs[4]  = '{OP_FRAME, 8'h03, 1'b1, 8'h01, 3'd3, 1'b0, 1'b0};
    vecs[5]  = '{OP_FRAME, 8'h04, 1'b1, 8'h01, 3'd4, 1'b0, 1'b0};
    vecs[6]  = '{OP_FRAME, 8'h05, 1'b1, 8'h01, 3'd4, 1'b1, 1'b0};
    vecs[7]  = '{OP_POP,   8'h00, 1'b1, 8'h01, 3'd3, 1'b1, 1'b0};
    vecs[8]  = '{OP_POP,   8'h00, 1'b1, 8'h02, 3'd2, 1'b1, 1'b0};
    vecs[9]  = '{OP_POP,   8'h00, 1'b1, 8'h03, 3'd1, 1'b1, 1'b0};
    vecs[10] = '{OP_POP,   8'h00, 1'b1, 8'h04, 3'd0, 1'b1, 1'b0};
    vecs[11] = '{OP_CLR,   8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[12] = '{OP_POP,   8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[13] = '{OP_FRAME, 8'h5A, 1'b1, 8'h5A, 3'd1, 1'b0, 1'b0};

    rst_n   = 1'b0;
    rx      = 1'b1;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    idle(3);
    check_status("reset", 3'd0, 1'b0, 1'b0);
    check("reset data_o", 32'(data_o), 32'h00);
    rst_n = 1'b1;
    idle(5);

    // Table: single frame and pop, overrun fill, drain, clear, empty pop.
    for (int i = 0; i < 14; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      case (vecs[i].op)
        OP_FRAME: begin
          send_frame(vecs[i].din, 1'b1, CPB, 1'b0);
          @(negedge clk);
          if (vecs[i].chk_head) check({tag, " head"}, 32'(data_o), 32'(vecs[i].exp_head));
        end
        OP_POP: pop(tag, vecs[i].chk_head, vecs[i].exp_head);
        default: begin
          @(posedge clk);
          #1;
          clr_err = 1'b1;
          @(posedge clk);
          #1;
          clr_err = 1'b0;
          @(negedge clk);
        end
      endcase
      check_status(tag, vecs[i].exp_count, vecs[i].exp_ovr, vecs[i].exp_fe);
    end
    pop("drain5A", 1'b1, 8'h5A);
    check_status("drain5A", 3'd0, 1'b0, 1'b0);

    // Short low glitch from idle must not start a frame.
    @(posedge clk);
    #1;
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(20);
    @(negedge clk);
    check_status("glitch", 3'd0, 1'b0, 1'b0);

    // Full FIFO with a pop in the stop-sample cycle: push and pop both happen.
    send_frame(8'h11, 1'b1, CPB, 1'b0);
    send_frame(8'h22, 1'b1, CPB, 1'b0);
    send_frame(8'h33, 1'b1, CPB, 1'b0);
    send_frame(8'h44, 1'b1, CPB, 1'b0);
    @(negedge clk);
    check_status("fill", 3'd4, 1'b0, 1'b0);
    send_frame(8'h99, 1'b1, CPB, 1'b1);
    @(negedge clk);
    check_status("popfull", 3'd4, 1'b0, 1'b0);
    pop("popfull d0", 1'b1, 8'h22);
    pop("popfull d1", 1'b1, 8'h33);
    pop("popfull d2", 1'b1, 8'h44);
    pop("popfull d3", 1'b1, 8'h99);
    check_status("popfull drained", 3'd0, 1'b0, 1'b0);

    // Stop bit held low: frame error, byte discarded, next frame still received.
    send_frame(8'h3C, 1'b0, 30, 1'b0);
    @(negedge clk);
    check_status("break", 3'd0, 1'b0, 1'b1);
    idle(10);
    send_frame(8'h7E, 1'b1, CPB, 1'b0);
    @(negedge clk);
    check("after break head", 32'(data_o), 32'h7E);
    check_status("after break", 3'd1, 1'b0, 1'b1);

    // Reset during bit 4 of 0x55 aborts the frame and clears FIFO and flags.
    @(posedge clk);
    #1;
    for (int b = 0; b < 5; b++) begin
      rx = (b == 0) ? 1'b0 : ((8'h55 >> (b - 1)) & 8'h01) != 8'h00;
      idle(int'(CPB));
    end
    rx = 1'b1;
    idle(5);
    rst_n = 1'b0;
    #1;
    check_status("midreset", 3'd0, 1'b0, 1'b0);
    check("midreset data_o", 32'(data_o), 32'h00);
    idle(3);
    rst_n = 1'b1;
    idle(20);
    @(negedge clk);
    check_status("post reset idle", 3'd0, 1'b0, 1'b0);
    send_frame(8'h12, 1'b1, CPB, 1'b0);
    @(negedge clk);
    check("post reset head", 32'(data_o), 32'h12);
    check_status("post reset", 3'd1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
